// File: rtl/seg7_scan2.sv
// Two-digit multiplexed seven-segment driver with per-frame input snapshot and anti-ghost blanking.
// Optional leading-zero blanking on the tens digit is enabled by defining SEG7_LZB_EN.
module seg7_scan2 #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int ACT_LOW   = 1
) (
    input  logic       clk,
    input  logic       rest_n,
    input  logic [6:0] ones,
    input  logic [6:0] tens,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int             DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DIV_MAX   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  BLANK_END = DW'(BLANK_CYC);
    localparam logic [DW-1:0]  DIV_ONE   = DW'(1);
    localparam logic [6:0]     SEG_OFF   = (ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]     AN_OFF    = (ACT_LOW != 0) ? 2'b11 : 2'b00;

    // BCD to active-high segment pattern; anything out of range shows a dash.
    function automatic logic [6:0] bcd_decode(input logic [6:0] v);
        logic [6:0] p;
        case (v)
            7'd0:    p = 7'h3F;
            7'd1:    p = 7'h06;
            7'd2:    p = 7'h5B;
            7'd3:    p = 7'h4F;
            7'd4:    p = 7'h66;
            7'd5:    p = 7'h6D;
            7'd6:    p = 7'h7D;
            7'd7:    p = 7'h07;
            7'd8:    p = 7'h7F;
            7'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] p);
        return (ACT_LOW != 0) ? (p ^ 7'h7F) : p;
    endfunction

    function automatic logic [1:0] an_pol(input logic [1:0] p);
        return (ACT_LOW != 0) ? (p ^ 2'b11) : p;
    endfunction

    logic [DW-1:0] div_r;
    logic          cur_r;
    logic [6:0]    sh_ones_r;
    logic [6:0]    sh_tens_r;
    logic [6:0]    seg_r;
    logic [1:0]    an_r;
    logic          frame_r;

    logic          wrap_s;
    logic          snap_s;
    logic          blank_s;
    logic [6:0]    digit_s;
    logic [6:0]    seg_nxt_s;
    logic [1:0]    an_nxt_s;

    assign wrap_s  = (div_r == DIV_MAX);
    assign snap_s  = wrap_s & cur_r;
    assign blank_s = (div_r < BLANK_END);
    assign digit_s = cur_r ? sh_tens_r : sh_ones_r;

    // Next display outputs, derived from the current slot position.
    always_comb begin
        seg_nxt_s = SEG_OFF;
        an_nxt_s  = AN_OFF;
        if (blank_s) begin
            seg_nxt_s = SEG_OFF;
            an_nxt_s  = AN_OFF;
        end else begin
            an_nxt_s = an_pol(cur_r ? 2'b10 : 2'b01);
`ifdef SEG7_LZB_EN
            if (cur_r && (sh_tens_r == 7'd0)) begin
                seg_nxt_s = SEG_OFF;
            end else begin
                seg_nxt_s = seg_pol(bcd_decode(digit_s));
            end
`else
            seg_nxt_s = seg_pol(bcd_decode(digit_s));
`endif
        end
    end

    // Slot divider and digit select; cur flips when the divider wraps.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            div_r <= '0;
            cur_r <= 1'b0;
        end else begin
            div_r <= wrap_s ? '0 : (div_r + DIV_ONE);
            cur_r <= wrap_s ? ~cur_r : cur_r;
        end
    end

    // Shadow copies of the digits, refreshed only at the end of the tens slot.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            sh_ones_r <= 7'd0;
            sh_tens_r <= 7'd0;
        end else if (snap_s) begin
            sh_ones_r <= ones;
            sh_tens_r <= tens;
        end else begin
            sh_ones_r <= sh_ones_r;
            sh_tens_r <= sh_tens_r;
        end
    end

    // Registered outputs; reset forces the display dark immediately.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            seg_r   <= SEG_OFF;
            an_r    <= AN_OFF;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_nxt_s;
            an_r    <= an_nxt_s;
            frame_r <= snap_s;
        end
    end

    assign seg   = seg_r;
    assign an    = an_r;
    assign frame = frame_r;

endmodule
